// File: rtl/memristor_program_ctrl.sv
// Program-and-verify sequencer for a single memristor cell.
// It alternates READ pulses with SET/RESET write pulses until the measured
// resistance is within TOL of the target, or until the pulse budget runs out.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   start, abort           begin operation (sampled in IDLE) / terminate operation
//   target_r               target memristance in ohms, captured on accepted start
//   r_meas, r_meas_valid   measured memristance from the read path
//   v_drive, v_valid       signed cell voltage in mV, and active-pulse flag
//   busy, done             operation in progress / one-cycle completion strobe
//   success, timeout_err   sticky result flags, cleared on the next accepted start
//   pulse_count            write pulses issued in the current or last operation
module memristor_program_ctrl #(
  parameter int V_WIDTH      = 16,
  parameter int R_WIDTH      = 16,
  parameter int V_SET        = 1000,
  parameter int V_RESET      = -1000,
  parameter int V_READ       = 100,
  parameter int PULSE_CYCLES = 4,
  parameter int READ_TIMEOUT = 16,
  parameter int MAX_PULSES   = 63,
  parameter int TOL          = 200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [R_WIDTH-1:0]        target_r,
  input  logic [R_WIDTH-1:0]        r_meas,
  input  logic                      r_meas_valid,
  output logic signed [V_WIDTH-1:0] v_drive,
  output logic                      v_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      success,
  output logic                      timeout_err,
  output logic [7:0]                pulse_count
);

  typedef enum logic [2:0] {StIdle, StRead, StCompare, StPulse, StGap, StDone} state_e;

  localparam logic signed [V_WIDTH-1:0] VSetC   = V_WIDTH'(V_SET);
  localparam logic signed [V_WIDTH-1:0] VResetC = V_WIDTH'(V_RESET);
  localparam logic signed [V_WIDTH-1:0] VReadC  = V_WIDTH'(V_READ);
  localparam logic [15:0]               ReadLastC  = 16'(READ_TIMEOUT - 1);
  localparam logic [15:0]               PulseLastC = 16'(PULSE_CYCLES - 1);
  localparam logic [7:0]                MaxPulsesC = 8'(MAX_PULSES);
  localparam logic [R_WIDTH:0]          TolC       = (R_WIDTH+1)'(TOL);

  state_e                      state_q, state_d;
  logic [R_WIDTH-1:0]          target_q, target_d;
  logic [R_WIDTH-1:0]          r_cap_q, r_cap_d;
  logic                        pol_set_q, pol_set_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [7:0]                  pulse_count_q, pulse_count_d;
  logic signed [V_WIDTH-1:0]   v_drive_q, v_drive_d;
  logic                        v_valid_q, v_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        success_q, success_d;
  logic                        timeout_err_q, timeout_err_d;

  // Both operands are zero-extended so the difference never overflows R_WIDTH+1 bits.
  logic signed [R_WIDTH:0] err;
  logic [R_WIDTH:0]        abs_err;
  logic                    in_tol;

  always_comb begin
    err     = $signed({1'b0, r_cap_q}) - $signed({1'b0, target_q});
    abs_err = err[R_WIDTH] ? (R_WIDTH+1)'(-err) : (R_WIDTH+1)'(err);
    in_tol  = (abs_err <= TolC);
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    r_cap_d       = r_cap_q;
    pol_set_d     = pol_set_q;
    cnt_d         = cnt_q;
    pulse_count_d = pulse_count_q;
    success_d     = success_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d      = target_r;
          pulse_count_d = '0;
          success_d     = 1'b0;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          state_d       = StRead;
        end
      end
      StRead: begin
        // abort takes priority over a simultaneous read result
        if (abort) begin
          state_d = StDone;
        end else if (r_meas_valid) begin
          r_cap_d = r_meas;
          state_d = StCompare;
        end else if (cnt_q == ReadLastC) begin
          timeout_err_d = 1'b1;
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StCompare: begin
        if (abort) begin
          state_d = StDone;
        end else if (in_tol) begin
          success_d = 1'b1;
          state_d   = StDone;
        end else if (pulse_count_q >= MaxPulsesC) begin
          state_d = StDone;
        end else begin
          // Positive error means R is too high, so SET to lower it.
          pol_set_d     = ~err[R_WIDTH];
          pulse_count_d = pulse_count_q + 8'd1;
          cnt_d         = '0;
          state_d       = StPulse;
        end
      end
      StPulse: begin
        if (abort) begin
          state_d = StDone;
        end else if (cnt_q == PulseLastC) begin
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StGap: begin
        cnt_d   = '0;
        state_d = abort ? StDone : StRead;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle) && (state_q != StDone)) begin
      success_d     = 1'b0;
      timeout_err_d = 1'b0;
    end

    // Outputs are registered, so they are decoded from the next state.
    v_valid_d = (state_d == StRead) || (state_d == StPulse);
    if (state_d == StRead) begin
      v_drive_d = VReadC;
    end else if (state_d == StPulse) begin
      v_drive_d = pol_set_d ? VSetC : VResetC;
    end else begin
      v_drive_d = '0;
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      target_q      <= '0;
      r_cap_q       <= '0;
      pol_set_q     <= 1'b0;
      cnt_q         <= '0;
      pulse_count_q <= '0;
      v_drive_q     <= '0;
      v_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      success_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      r_cap_q       <= r_cap_d;
      pol_set_q     <= pol_set_d;
      cnt_q         <= cnt_d;
      pulse_count_q <= pulse_count_d;
      v_drive_q     <= v_drive_d;
      v_valid_q     <= v_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      success_q     <= success_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign v_drive     = v_drive_q;
  assign v_valid     = v_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign success     = success_q;
  assign timeout_err = timeout_err_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_memristor_program_ctrl.sv
// Bench for memristor_program_ctrl: a table of whole operations against a
// simple read-path model, plus hand-written abort, reset and budget sequences.
module tb_memristor_program_ctrl;

  localparam int VSet   = 1000;
  localparam int VRead  = 100;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, valid, start2, valid2;
  logic [15:0] target_r, r_meas;

  logic signed [15:0] v_drive, v_drive2;
  logic        v_valid, busy, done, success, timeout_err;
  logic        v_valid2, busy2, done2, success2, timeout_err2;
  logic [7:0]  pulse_count, pulse_count2;

  int n_tests = 0;
  int n_fail  = 0;

  // Read-path model: resistance moves by r_step per write pulse since pulse_base.
  int r_base = 0, r_step = 0, pulse_base = 0;
  int mon_sets = 0, mon_resets = 0, mon_reads = 0, bad_len = 0, in_len = 0;
  int mon2_pulses = 0;
  bit in_p = 1'b0, in_p2 = 1'b0;

  assign r_meas = 16'(r_base - r_step * (mon_sets + mon_resets - pulse_base));

  always #5 clk = ~clk;

  memristor_program_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .target_r    (target_r),
    .r_meas      (r_meas),
    .r_meas_valid(valid),
    .v_drive     (v_drive),
    .v_valid     (v_valid),
    .busy        (busy),
    .done        (done),
    .success     (success),
    .timeout_err (timeout_err),
    .pulse_count (pulse_count)
  );

  memristor_program_ctrl #(.MAX_PULSES(3)) u_dut_b3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .abort       (abort),
    .target_r    (target_r),
    .r_meas      (r_meas),
    .r_meas_valid(valid2),
    .v_drive     (v_drive2),
    .v_valid     (v_valid2),
    .busy        (busy2),
    .done        (done2),
    .success     (success2),
    .timeout_err (timeout_err2),
    .pulse_count (pulse_count2)
  );

  // Pulse monitor: counts SET/RESET pulses, READ cycles and wrong-length pulses.
  always @(negedge clk) begin
    if (v_valid && int'(v_drive) != VRead) begin
      if (!in_p) begin
        if (int'(v_drive) == VSet) mon_sets++;
        else mon_resets++;
        in_len = 1;
        in_p   = 1'b1;
      end else begin
        in_len++;
      end
    end else if (in_p) begin
      if (in_len != 4) bad_len++;
      in_p = 1'b0;
    end
    if (v_valid && int'(v_drive) == VRead) mon_reads++;
    if (v_valid2 && int'(v_drive2) == VSet && !in_p2) mon2_pulses++;
    in_p2 = v_valid2 && int'(v_drive2) == VSet;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns cycles from the start edge to the done cycle.
  task automatic run_op(input logic [15:0] tgt, input int limit, output int cyc);
    target_r = tgt;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_set_pulse(input string nm);
    int n = 0;
    while (!(v_valid && int'(v_drive) == VSet) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(v_valid && int'(v_drive) == VSet), 1);
  endtask

  typedef struct {
    int tgt; int rb; int rs; bit vld;
    bit succ; bit tmo; int pc; int sets; int resets; int reads; int cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc, s0, r0, rd0, b0, p0;

    //          tgt    rb     rs     vld succ tmo pc  sets rst reads cyc
    vecs[0] = '{2000,  8050,  1000,  1,  1,   0,  6,  6,   0,  7,    45};
    vecs[1] = '{10000, 9800,  0,     1,  1,   0,  0,  0,   0,  1,    3};
    vecs[2] = '{10000, 10200, 0,     1,  1,   0,  0,  0,   0,  1,    3};
    vecs[3] = '{10000, 10201, 0,     1,  0,   0,  63, 63,  0,  64,   444};
    vecs[4] = '{10000, 9799,  0,     1,  0,   0,  63, 0,   63, 64,   444};
    vecs[5] = '{0,     65535, 0,     1,  0,   0,  63, 63,  0,  64,   444};
    vecs[6] = '{10000, 7000,  -1000, 1,  1,   0,  3,  0,   3,  4,    24};
    vecs[7] = '{500,   0,     0,     0,  0,   1,  0,  0,   0,  16,   17};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
    start2 = 1'b0; valid2 = 1'b0; target_r = '0;
    repeat (2) @(negedge clk);
    check("rst.v_drive", int'(v_drive), 0);
    check("rst.v_valid", v_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.success", success, 0);
    check("rst.timeout_err", timeout_err, 0);
    check("rst.pulse_count", pulse_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      r_base = vecs[i].rb;
      r_step = vecs[i].rs;
      valid  = vecs[i].vld;
      pulse_base = mon_sets + mon_resets;
      s0 = mon_sets; r0 = mon_resets; rd0 = mon_reads; b0 = bad_len;
      run_op(16'(vecs[i].tgt), 1000, cyc);
      check($sformatf("v%0d.done", i), done, 1);
      check($sformatf("v%0d.cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d.success", i), success, int'(vecs[i].succ));
      check($sformatf("v%0d.timeout_err", i), timeout_err, int'(vecs[i].tmo));
      check($sformatf("v%0d.pulse_count", i), pulse_count, vecs[i].pc);
      check($sformatf("v%0d.set_pulses", i), mon_sets - s0, vecs[i].sets);
      check($sformatf("v%0d.reset_pulses", i), mon_resets - r0, vecs[i].resets);
      check($sformatf("v%0d.read_cycles", i), mon_reads - rd0, vecs[i].reads);
      check($sformatf("v%0d.bad_pulse_len", i), bad_len - b0, 0);
      @(negedge clk);
      check($sformatf("v%0d.idle_busy", i), busy, 0);
      check($sformatf("v%0d.idle_done", i), done, 0);
      check($sformatf("v%0d.held_success", i), success, int'(vecs[i].succ));
    end

    // abort in IDLE does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort.busy", busy, 0);
    check("idle_abort.done", done, 0);

    // start and abort together in IDLE: start wins
    r_base = 10000; r_step = 0; valid = 1'b1;
    target_r = 16'd10000; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort.busy", busy, 1);
    check("start_abort.v_drive", int'(v_drive), VRead);
    repeat (2) @(negedge clk);
    check("start_abort.done", done, 1);
    check("start_abort.success", success, 1);
    @(negedge clk);

    // abort beats a valid read in the same READ cycle
    target_r = 16'd10000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_read.done", done, 1);
    check("abort_read.success", success, 0);
    check("abort_read.v_valid", v_valid, 0);
    @(negedge clk);

    // abort on the 2nd PULSE cycle
    r_base = 8050; r_step = 0; pulse_base = mon_sets + mon_resets;
    target_r = 16'd2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_set_pulse("abort_pulse.reached");
    @(negedge clk);
    check("abort_pulse.still_pulsing", v_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse.v_drive", int'(v_drive), 0);
    check("abort_pulse.v_valid", v_valid, 0);
    check("abort_pulse.done", done, 1);
    check("abort_pulse.success", success, 0);
    check("abort_pulse.timeout_err", timeout_err, 0);
    check("abort_pulse.pulse_count", pulse_count, 1);
    @(negedge clk);

    // asynchronous reset during PULSE
    target_r = 16'd2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_set_pulse("async_rst.reached");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.v_drive", int'(v_drive), 0);
    check("async_rst.v_valid", v_valid, 0);
    check("async_rst.busy", busy, 0);
    check("async_rst.pulse_count", pulse_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r_base = 10000;
    run_op(16'd10000, 100, cyc);
    check("after_rst.cycles", cyc, 3);
    check("after_rst.success", success, 1);
    @(negedge clk);

    // pulse budget of 3 on the second instance
    r_base = 16000; r_step = 0; valid = 1'b0; valid2 = 1'b1;
    p0 = mon2_pulses;
    target_r = 16'd100; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("budget.done", done2, 1);
    check("budget.cycles", cyc, 24);
    check("budget.pulses", mon2_pulses - p0, 3);
    check("budget.pulse_count", pulse_count2, 3);
    check("budget.success", success2, 0);
    check("budget.timeout_err", timeout_err2, 0);
    valid2 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memristor_program_ctrl.md
Name: memristor_program_ctrl

Overview:
- Program-and-verify sequencer sitting directly upstream of the memristor cell model.
- Drives the cell voltage as a signed mV code and alternates READ pulses with SET/RESET write pulses.
- Consumes the measured memristance (integer ohms) until the cell lands within tolerance of a target, or the pulse budget is exhausted.
- Used by the crossbar initialisation flow to program one cell at a time.

Parameters:
- V_WIDTH, 16, width of signed voltage code (1 LSB = 1 mV)
- R_WIDTH, 16, width of unsigned resistance code (1 LSB = 1 ohm)
- V_SET, 1000, write voltage that lowers R (drives w toward D), mV
- V_RESET, -1000, write voltage that raises R, mV
- V_READ, 100, non-destructive read voltage, mV
- PULSE_CYCLES, 4, clock cycles per write pulse (>=1)
- READ_TIMEOUT, 16, max cycles in READ waiting for r_meas_valid
- MAX_PULSES, 63, write pulse budget per operation (1..255)
- TOL, 200, acceptance band in ohms, inclusive

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- abort  in  1  terminate current operation
- target_r  in  R_WIDTH  target memristance; captured on accepted start
- r_meas  in  R_WIDTH  measured memristance from the read path
- r_meas_valid  in  1  r_meas is valid this cycle
- v_drive  out  V_WIDTH signed  voltage applied to the cell; 0 when not pulsing
- v_valid  out  1  v_drive is an active pulse
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle completion strobe
- success  out  1  last operation converged; held until the next accepted start
- timeout_err  out  1  last operation ended on read timeout; held until the next accepted start
- pulse_count  out  8  write pulses issued in the current or last operation

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; v_drive=0, v_valid=0, busy=0, done=0, success=0, timeout_err=0, pulse_count=0.
  - Internal target and captured R cleared.
- All outputs are registered.
- States: IDLE, READ, COMPARE, PULSE, GAP, DONE.
- IDLE:
  - start=1 captures target_r, clears pulse_count/success/timeout_err, moves to READ next cycle.
  - start while busy is ignored.
- READ:
  - v_drive=V_READ, v_valid=1.
  - First cycle with r_meas_valid=1 captures r_meas and moves to COMPARE; v_drive=0 and v_valid=0 from the next cycle.
  - r_meas_valid outside READ is ignored.
  - READ_TIMEOUT cycles without valid: go to DONE with timeout_err=1, success=0.
- COMPARE (1 cycle, v_valid=0):
  - err = r_cap - target in signed R_WIDTH+1 bits; |err|<=TOL: DONE, success=1.
  - Else if pulse_count==MAX_PULSES: DONE, success=0.
  - Else go to PULSE, with polarity V_SET if r_cap>target, otherwise V_RESET.
- PULSE:
  - v_drive=polarity, v_valid=1 for exactly PULSE_CYCLES cycles.
  - pulse_count increments once, on the first cycle.
  - Then GAP.
- GAP: 1 cycle, v_drive=0, v_valid=0; then READ.
- DONE: done=1 for one cycle, busy=1 during it; next cycle IDLE with busy=0.
- Latency: start to first READ cycle = 1 clock. An in-tolerance cell on the first read with r_meas_valid in the first READ cycle gives done 3 clocks after start (READ, COMPARE, DONE).
- abort=1 in READ/COMPARE/PULSE/GAP:
  - Next state DONE; v_drive=0 and v_valid=0 next cycle; success=0, timeout_err=0.
  - A partially issued pulse still counts.
  - abort in IDLE or DONE has no effect.
- abort and r_meas_valid in the same READ cycle: abort wins.
- start and abort both high in IDLE: start accepted, abort ignored.
- Reset mid-pulse forces v_drive=0 immediately (asynchronous).
- pulse_count saturates at MAX_PULSES; it never wraps.
- target_r changes while busy have no effect.

Test Plan:
- Converge downward: target_r=2000, read path returns 8050 then decreases 1000 per pulse. Required: V_SET pulses of 4 cycles each, done with success=1, pulse_count=6 (final read 2050, |err|=50<=TOL).
- Converge upward with boundary: target_r=10000, first read 9800. Required: no pulse issued (|err|=200 equals TOL, inclusive), success=1, pulse_count=0.
- Budget exhaustion: MAX_PULSES=3, r_meas stuck at 16000, target_r=100. Required: exactly 3 V_SET pulses, done with success=0, pulse_count=3.
- Read timeout: r_meas_valid never asserted. Required: 16 READ cycles at v_drive=100, then done with timeout_err=1, success=0, pulse_count=0.
- Abort mid-pulse: abort on the 2nd PULSE cycle. Required: v_drive=0 next cycle, done strobe, success=0, pulse_count=1.
- Async reset during PULSE: rst_n low mid-cycle. Required: v_drive=0, v_valid=0, busy=0 without waiting for a clock edge; start after release runs normally.
